// File: rtl/arith_port_sequencer.sv
// rtl/arith_port_sequencer.sv - port B sequencer: streams RAM operands out, writes results back
//
// Purpose: arithmetic-side client of the dual-port operand RAM. On start it reads
// count words from rd_base upward and streams them to the arithmetic unit. It then
// writes each returned result to wr_base+k in acceptance order.
//
// Ports:
//   ram_clock, resetn         clock, synchronous active-low reset
//   start, rd_base, wr_base,  job request; job parameters are sampled on an accepted start
//   count                     (count is clamped to 2^ADDR_WIDTH)
//   busy, done                job status (done is a one-cycle pulse)
//   addr_arith, data_arith,   RAM port B address, write data, write enable
//   we_arith, q_arith         and read data (one-cycle read latency)
//   op_data/op_valid/op_ready operand stream to the arithmetic unit
//   res_data/res_valid/       result stream from the arithmetic unit
//   res_ready
module arith_port_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  ram_clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_arith,
  output logic [DATA_WIDTH-1:0] data_arith,
  output logic                  we_arith,
  input  logic [DATA_WIDTH-1:0] q_arith,
  output logic [DATA_WIDTH-1:0] op_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_valid,
  output logic                  res_ready
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] rd_base_r;
  logic [ADDR_WIDTH-1:0] wr_base_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   rd_issued;
  logic [ADDR_WIDTH:0]   op_sent;
  logic [ADDR_WIDTH:0]   res_taken;
  logic                  rd_inflight;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  fifo_wptr;
  logic                  fifo_rptr;
  logic [1:0]            fifo_occ;

  logic                  wr_pend;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;

  logic                  start_acc;
  logic                  job_complete;
  logic                  rd_issue;
  logic                  op_pop;
  logic                  res_fire;
  logic [1:0]            rd_pressure;
  logic [ADDR_WIDTH:0]   count_clamped;

  assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;

  // Buffer slots already promised: captured words plus the read whose data
  // arrives on q_arith this cycle.
  assign rd_pressure = fifo_occ + {1'b0, rd_inflight};

  // A pending write owns the single port, so a read waits for it.
  assign rd_issue = (state == RUN) && !wr_pend && (rd_pressure < 2'd2) && (rd_issued < count_r);

  assign op_valid = (fifo_occ != 2'd0);
  assign op_data  = fifo_mem[fifo_rptr];
  assign op_pop   = op_valid && op_ready;

  assign res_ready = (state == RUN) && !wr_pend && (res_taken < count_r);
  assign res_fire  = res_valid && res_ready;

  // Port B is driven from registered state only; stream inputs never reach it combinationally.
  assign addr_arith = wr_pend  ? wr_addr_r :
                      rd_issue ? rd_base_r + rd_issued[ADDR_WIDTH-1:0] : '0;
  assign data_arith = wr_pend ? wr_data_r : '0;
  assign we_arith   = wr_pend && (state == RUN);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign job_complete = (rd_issued == count_r) && (op_sent == count_r) &&
                        (res_taken == count_r) && !wr_pend;

  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (job_complete) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ram_clock) begin
    if (!resetn) begin
      state       <= IDLE;
      rd_base_r   <= '0;
      wr_base_r   <= '0;
      count_r     <= '0;
      rd_issued   <= '0;
      op_sent     <= '0;
      res_taken   <= '0;
      rd_inflight <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wptr   <= 1'b0;
      fifo_rptr   <= 1'b0;
      fifo_occ    <= 2'd0;
      wr_pend     <= 1'b0;
      wr_data_r   <= '0;
      wr_addr_r   <= '0;
    end else begin
      state <= state_n;

      if (start_acc) begin
        rd_base_r <= rd_base;
        wr_base_r <= wr_base;
        count_r   <= count_clamped;
        rd_issued <= '0;
        op_sent   <= '0;
        res_taken <= '0;
      end else begin
        if (rd_issue) begin
          rd_issued <= rd_issued + 1'b1;
        end
        if (op_pop) begin
          op_sent <= op_sent + 1'b1;
        end
        if (res_fire) begin
          res_taken <= res_taken + 1'b1;
        end
      end

      // q_arith holds the word addressed in the previous cycle.
      rd_inflight <= rd_issue;
      if (rd_inflight) begin
        fifo_mem[fifo_wptr] <= q_arith;
        fifo_wptr           <= ~fifo_wptr;
      end
      if (op_pop) begin
        fifo_rptr <= ~fifo_rptr;
      end
      fifo_occ <= fifo_occ + {1'b0, rd_inflight} - {1'b0, op_pop};

      if (res_fire) begin
        wr_pend   <= 1'b1;
        wr_data_r <= res_data;
        wr_addr_r <= wr_base_r + res_taken[ADDR_WIDTH-1:0];
      end else if (wr_pend) begin
        wr_pend <= 1'b0;
      end
    end
  end

endmodule
